matmul_host_port_driver: RTL and testbench
==========================================

# matmul_host_port_driver

Host-side driver for the external (second) port of the matrix-multiplication block's BRAMs. It accepts a 64-bit input stream and writes the A and B operand tiles into A_0_0, A_1_0, B_0_0 and B_0_1. It then starts the multiply and waits for completion. Finally it reads the C_1_0 and C_1_1 result tiles back out as a 64-bit output stream with backpressure.

## Interface
- DWIDTH, 8, element width in bits
- AWIDTH, 11, BRAM byte-address width
- MAT_MUL_SIZE, 8, rows per tile and elements per BRAM word; word = MAT_MUL_SIZE*DWIDTH = 64 bits
- clk  in  1  clock, same as clk_mem
- resetn  in  1  reset, synchronous, active-low
- op_start  in  1  one-cycle pulse; begins a job when idle, ignored otherwise
- base_a, base_b, base_c  in  AWIDTH  start addresses, sampled at op_start
- stride  in  8  address increment per row, sampled at op_start
- in_data  in  64  load stream data
- in_valid  in  1  load stream valid
- in_ready  out  1  load stream ready
- out_data  out  64  unload stream data
- out_valid  out  1  unload stream valid
- out_ready  in  1  unload stream ready
- ext_addr  out  AWIDTH  address driven to all six external BRAM ports
- ext_wdata  out  64  write data driven to the four A/B external ports
- we_a00, we_a10, we_b00, we_b01  out  8 each  per-BRAM byte write enables
- rdata_c10, rdata_c11  in  64  external read data from C_1_0 and C_1_1
- mm_start  out  1  drives start_reg
- mm_clear  out  1  drives clear_done_reg
- mm_done  in  1  matmul done level, held until clear
- busy  out  1  high from op_start acceptance until the job ends
- job_done  out  1  one-cycle pulse when a job completes

## Operation
- States: IDLE, LOAD, KICK, WAIT, RADDR, RDATA, OUT, CLEAR.
- IDLE: when op_start=1, latch the bases and stride, clear counters, set busy and go to LOAD.
- LOAD:
  - in_ready=1. Each in_valid&in_ready beat writes one word.
  - The 5-bit counter k (0..31) selects the target: k[4:3]=0 → A00 (base_a), 1 → A10 (base_a), 2 → B00 (base_b), 3 → B01 (base_b).
  - Row r=k[2:0]. Address = base + r*stride, truncated to AWIDTH (modulo wrap).
  - ext_addr and ext_wdata are driven combinationally from the current beat. The selected we_* is 8'hFF for that cycle; the other enables are 0.
  - After the beat with k=31, go to KICK.
- KICK: mm_start=1 for exactly one cycle, then go to WAIT.
- WAIT: hold until mm_done=1, then go to RADDR.
- RADDR:
  - 4-bit counter j (0..15). j[3]=0 reads C10, j[3]=1 reads C11.
  - ext_addr = base_c + j[2:0]*stride. Go to RDATA.
- RDATA: the BRAM output is valid this cycle. Capture rdata_c10 or rdata_c11 (selected by j[3]) into the out_data register, set out_valid and go to OUT.
- OUT:
  - Hold out_data and out_valid until out_ready=1.
  - On the handshake: if j=15 go to CLEAR; otherwise j++ and go to RADDR.
- CLEAR: mm_clear=1 for one cycle, job_done=1, busy falls, go to IDLE.
- ext_wdata is 0 and all we_* are 0 outside write beats.
- The block never asserts in_ready outside LOAD and never asserts out_valid outside OUT.

## Timing
- Reset values: state IDLE; in_ready, out_valid, mm_start, mm_clear, busy and job_done = 0; out_data, ext_addr and ext_wdata = 0; all we_* = 0. The k and j counters reset to 0.
- busy is registered: it rises the cycle after op_start.
- Load phase: one word per cycle at full rate, 32 cycles minimum.
- mm_start pulses one cycle after the 32nd write.
- Unload phase:
  - 3 cycles per word minimum: RADDR, RDATA, then OUT with out_ready=1.
  - out_valid first rises 2 cycles after the WAIT→RADDR transition.
- A job takes 32 + 1 + (wait) + 48 + 1 cycles minimum.
- Simultaneous events:
  - mm_done already high on entering WAIT: leave WAIT the next cycle.
  - op_start while busy: ignored.
- Reset mid-job: all outputs return to their reset values at the next clock edge. BRAM contents are untouched. No mm_clear is issued.
- A pause in in_valid simply stalls LOAD with no writes.
- out_ready held low stalls OUT indefinitely with out_data stable.

## Test plan
- Basic job: bases a=0, b=64, c=128, stride=8; stream words 0..31 = 64'h0101…×k.
  - A00 row 3 is written at address 24 with we_a00=8'hFF.
  - B01 row 7 is written at address 120.
  - After mm_done, C10 rows 0..7 are output followed by C11 rows 0..7.
  - The output matches the C BRAM model data.
- Load backpressure: toggle in_valid every other cycle. Exactly 32 write pulses occur, never two we_* high at once, and mm_start pulses exactly once.
- Unload backpressure: out_ready=0 for 10 cycles at j=5. out_data is stable, with no address advance, and all 16 words arrive in order.
- Address wrap: base_c=2040, stride=8. Row 1 is read at address 0 (11-bit wrap).
- Reset mid-WAIT: deassert resetn for one cycle. busy=0 and mm_start=mm_clear=0. A new op_start then completes a full job correctly.
- op_start pulsed during LOAD and during OUT: ignored, and exactly one job_done is produced.

Source files
------------

// File: rtl/matmul_host_port_driver.sv
// matmul_host_port_driver: loads A/B operand tiles from a 64-bit stream into the
//   external BRAM ports, kicks the multiply, waits for done, then streams C_1_0/C_1_1 back out.
// Ports: op_start/base_a/base_b/base_c/stride (job setup), in_* (load stream, valid/ready),
//   out_* (unload stream, valid/ready), ext_addr/ext_wdata/we_* (BRAM port B writes),
//   rdata_c10/rdata_c11 (BRAM reads), mm_start/mm_clear/mm_done (matmul control), busy/job_done.
// Latency: 32 load beats + 1 kick + wait + 3 cycles per result word + 1 clear; load and unload
//   both stall cleanly on in_valid low / out_ready low.
module matmul_host_port_driver #(
  parameter int DWIDTH       = 8,
  parameter int AWIDTH       = 11,
  parameter int MAT_MUL_SIZE = 8
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic                                op_start,
  input  logic [AWIDTH-1:0]                   base_a,
  input  logic [AWIDTH-1:0]                   base_b,
  input  logic [AWIDTH-1:0]                   base_c,
  input  logic [7:0]                          stride,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0]      in_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0]      out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [AWIDTH-1:0]                   ext_addr,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0]      ext_wdata,
  output logic [MAT_MUL_SIZE*DWIDTH/8-1:0]    we_a00,
  output logic [MAT_MUL_SIZE*DWIDTH/8-1:0]    we_a10,
  output logic [MAT_MUL_SIZE*DWIDTH/8-1:0]    we_b00,
  output logic [MAT_MUL_SIZE*DWIDTH/8-1:0]    we_b01,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0]      rdata_c10,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0]      rdata_c11,
  output logic                                mm_start,
  output logic                                mm_clear,
  input  logic                                mm_done,
  output logic                                busy,
  output logic                                job_done
);

  localparam int WW = MAT_MUL_SIZE * DWIDTH;
  localparam int BW = WW / 8;
  localparam int RW = $clog2(MAT_MUL_SIZE);
  localparam int OW = RW + 8;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_KICK, S_WAIT, S_RADDR, S_RDATA, S_OUT, S_CLEAR
  } state_t;

  state_t            state, state_nxt;
  logic [RW+1:0]     k;          // load beat: {tile[1:0], row}
  logic [RW:0]       j;          // unload word: {C11 select, row}
  logic [AWIDTH-1:0] base_a_q, base_b_q, base_c_q;
  logic [7:0]        stride_q;

  logic              beat;
  logic              last_k, last_j;
  logic [RW-1:0]     row;
  logic [AWIDTH-1:0] base_sel;
  logic [OW-1:0]     row_off;
  logic [AWIDTH-1:0] addr_calc;

  assign beat   = (state == S_LOAD) && in_valid;
  assign last_k = &k;
  assign last_j = &j;

  // One shared address generator: load rows come from k, unload rows from j.
  // The sum is kept at AWIDTH bits so addresses wrap modulo the BRAM size.
  always_comb begin
    row      = k[RW-1:0];
    base_sel = k[RW+1] ? base_b_q : base_a_q;
    if (state != S_LOAD) begin
      row      = j[RW-1:0];
      base_sel = base_c_q;
    end
    row_off   = OW'(row) * OW'(stride_q);
    addr_calc = base_sel + AWIDTH'(row_off);
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    mm_start  = 1'b0;
    mm_clear  = 1'b0;
    job_done  = 1'b0;
    busy      = (state != S_IDLE);
    ext_addr  = '0;
    ext_wdata = '0;
    we_a00    = '0;
    we_a10    = '0;
    we_b00    = '0;
    we_b01    = '0;
    case (state)
      S_IDLE: begin
        if (op_start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        ext_addr = addr_calc;
        if (in_valid) begin
          ext_wdata = in_data;
          case (k[RW+1:RW])
            2'd0:    we_a00 = {BW{1'b1}};
            2'd1:    we_a10 = {BW{1'b1}};
            2'd2:    we_b00 = {BW{1'b1}};
            default: we_b01 = {BW{1'b1}};
          endcase
          if (last_k) state_nxt = S_KICK;
        end
      end
      S_KICK: begin
        mm_start  = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (mm_done) state_nxt = S_RADDR;
      end
      S_RADDR: begin
        ext_addr  = addr_calc;
        state_nxt = S_RDATA;
      end
      S_RDATA: begin
        // Address is held so the registered BRAM output stays aligned.
        ext_addr  = addr_calc;
        state_nxt = S_OUT;
      end
      S_OUT: begin
        ext_addr  = addr_calc;
        out_valid = 1'b1;
        if (out_ready) state_nxt = last_j ? S_CLEAR : S_RADDR;
      end
      S_CLEAR: begin
        mm_clear  = 1'b1;
        job_done  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= S_IDLE;
      k        <= '0;
      j        <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
      base_c_q <= '0;
      stride_q <= '0;
      out_data <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (op_start) begin
            base_a_q <= base_a;
            base_b_q <= base_b;
            base_c_q <= base_c;
            stride_q <= stride;
            k        <= '0;
            j        <= '0;
          end
        end
        S_LOAD:  if (in_valid) k <= k + 1'b1;
        S_RDATA: out_data <= j[RW] ? rdata_c11 : rdata_c10;
        S_OUT:   if (out_ready && !last_j) j <= j + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_host_port_driver.sv
// tb_matmul_host_port_driver: self-checking bench for matmul_host_port_driver.
// Ports: drives every DUT port; models the matmul done handshake and the C BRAMs.
// Jobs come from a vector table; a reset-in-WAIT sequence is hand-written.
module tb_matmul_host_port_driver;

  logic        clk = 1'b0;
  logic        resetn;
  logic        op_start;
  logic [10:0] base_a, base_b, base_c;
  logic [7:0]  stride;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] ext_addr;
  logic [63:0] ext_wdata;
  logic [7:0]  we_a00, we_a10, we_b00, we_b01;
  logic [63:0] rdata_c10, rdata_c11;
  logic        mm_start, mm_clear, mm_done;
  logic        busy, job_done;

  always #5 clk = ~clk;

  matmul_host_port_driver dut (
    .clk(clk), .resetn(resetn), .op_start(op_start),
    .base_a(base_a), .base_b(base_b), .base_c(base_c), .stride(stride),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .we_a00(we_a00), .we_a10(we_a10), .we_b00(we_b00), .we_b01(we_b01),
    .rdata_c10(rdata_c10), .rdata_c11(rdata_c11),
    .mm_start(mm_start), .mm_clear(mm_clear), .mm_done(mm_done),
    .busy(busy), .job_done(job_done)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // C BRAM contents: a recognisable word per (tile, byte address).
  function automatic logic [63:0] c_word(input logic sel, input logic [10:0] a);
    return {sel ? 32'hC11C11C1 : 32'hC10C10C1, 5'd0, a, 16'hBEEF};
  endfunction

  function automatic logic [10:0] model_addr(input int base, input int r, input int st);
    return 11'((base + r * st) % 2048);
  endfunction

  always @(posedge clk) begin
    rdata_c10 <= c_word(1'b0, ext_addr);
    rdata_c11 <= c_word(1'b1, ext_addr);
  end

  // Matmul model: done rises done_dly cycles after start (0 = already high on entering WAIT).
  int done_dly = 0;
  int dcnt;
  always @(posedge clk) begin
    if (!resetn) begin
      mm_done <= 1'b0;
      dcnt    <= 0;
    end else begin
      if (mm_clear) mm_done <= 1'b0;
      if (mm_start) begin
        if (done_dly == 0) mm_done <= 1'b1;
        else dcnt <= done_dly;
      end else if (dcnt > 0) begin
        dcnt <= dcnt - 1;
        if (dcnt == 1) mm_done <= 1'b1;
      end
    end
  end

  // Monitor: monotonic event counters and a write log.
  typedef struct {
    int          sel;
    logic [10:0] addr;
    logic [63:0] dat;
    logic [7:0]  we;
  } wr_t;
  wr_t wr_q[$];
  int n_start = 0, n_jdone = 0, n_clear = 0, n_busy = 0, n_viol = 0;

  always @(negedge clk) begin
    int  nwe;
    wr_t w;
    if (resetn) begin
      if (mm_start) n_start++;
      if (job_done) n_jdone++;
      if (mm_clear) n_clear++;
      if (busy)     n_busy++;
      nwe = int'(we_a00 != 0) + int'(we_a10 != 0) + int'(we_b00 != 0) + int'(we_b01 != 0);
      if (in_valid && in_ready) begin
        if (nwe != 1) n_viol++;
        w.sel  = (we_a00 != 0) ? 0 : (we_a10 != 0) ? 1 : (we_b00 != 0) ? 2 : 3;
        w.addr = ext_addr;
        w.dat  = ext_wdata;
        w.we   = we_a00 | we_a10 | we_b00 | we_b01;
        wr_q.push_back(w);
      end else if (nwe != 0 || ext_wdata != 0) begin
        n_viol++;
      end
      if ((in_ready || out_valid) && !busy) n_viol++;
    end
  end

  typedef struct {
    logic [10:0] ba, bb, bc;
    logic [7:0]  st;
    int          in_mode;    // 0 full rate, 1 alternate, 2 random
    int          stall_j;    // output index to stall at (-1 none)
    int          stall_len;
    int          dly;
    bit          extra_start;
    bit          ramp;
    logic [10:0] exp_a00_r3;
    logic [10:0] exp_b01_r7;
    logic [10:0] exp_c_r1;
    int          exp_busy;   // 0 = not checked
  } vec_t;

  vec_t vecs[6];

  task automatic run_job(input vec_t v, input int id);
    logic [63:0] din[32];
    logic [63:0] outs[$];
    logic [63:0] sd;
    logic [10:0] sa;
    int s0, j0, c0, b0, v0, w0, n, cyc, got, stall_left;
    bit vb, done_seen, fired;
    s0 = n_start; j0 = n_jdone; c0 = n_clear; b0 = n_busy; v0 = n_viol; w0 = wr_q.size();
    for (int i = 0; i < 32; i++)
      din[i] = v.ramp ? 64'h0101010101010101 * 64'(i) : {$urandom, $urandom};
    done_dly = v.dly;

    @(posedge clk); #1;
    op_start = 1'b1; base_a = v.ba; base_b = v.bb; base_c = v.bc; stride = v.st;
    @(posedge clk); #1;
    op_start = 1'b0;
    chk($sformatf("j%0d busy_rise", id), 64'(busy), 64'd1);

    n = 0; cyc = 0;
    while (n < 32 && cyc < 400) begin
      case (v.in_mode)
        0:       vb = 1'b1;
        1:       vb = (cyc % 2) == 0;
        default: vb = $urandom_range(0, 2) != 0;
      endcase
      in_valid = vb;
      in_data  = vb ? din[n] : {$urandom, $urandom};
      op_start = v.extra_start && (cyc == 10);
      @(negedge clk);
      if (vb && in_ready) n++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; in_data = '0; op_start = 1'b0;
    chk($sformatf("j%0d load_beats", id), 64'(n), 64'd32);

    got = 0; cyc = 0; done_seen = 0; fired = 0; stall_left = v.stall_len;
    sd = '0; sa = '0;
    while (!done_seen && cyc < 3000) begin
      op_start = 1'b0;
      if (v.extra_start && !fired && out_valid && got == 3) begin
        op_start = 1'b1;
        fired = 1'b1;
      end
      if (out_valid && got == v.stall_j && stall_left > 0) begin
        out_ready = 1'b0;
        if (stall_left == v.stall_len) begin
          sd = out_data;
          sa = ext_addr;
        end else begin
          chk($sformatf("j%0d stall_data", id), out_data, sd);
          chk($sformatf("j%0d stall_addr", id), 64'(ext_addr), 64'(sa));
        end
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
      if (out_valid && out_ready) begin
        outs.push_back(out_data);
        got++;
      end
      if (job_done) done_seen = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0; op_start = 1'b0;
    chk($sformatf("j%0d job_done_seen", id), 64'(done_seen), 64'd1);
    chk($sformatf("j%0d out_count", id), 64'(got), 64'd16);
    for (int i = 0; i < 16 && i < got; i++)
      chk($sformatf("j%0d out_word%0d", id, i), outs[i],
          c_word(i >= 8, model_addr(int'(v.bc), i % 8, int'(v.st))));
    if (got > 1) chk($sformatf("j%0d c10_row1", id), outs[1], c_word(1'b0, v.exp_c_r1));

    chk($sformatf("j%0d wr_count", id), 64'(wr_q.size() - w0), 64'd32);
    for (int i = 0; i < 32 && (w0 + i) < wr_q.size(); i++) begin
      chk($sformatf("j%0d wr%0d sel/addr/we", id, i),
          {32'(wr_q[w0+i].sel), 13'd0, wr_q[w0+i].addr, wr_q[w0+i].we},
          {32'(i / 8), 13'd0,
           model_addr(i < 16 ? int'(v.ba) : int'(v.bb), i % 8, int'(v.st)), 8'hFF});
      chk($sformatf("j%0d wr%0d data", id, i), wr_q[w0+i].dat, din[i]);
    end
    if (wr_q.size() >= w0 + 32) begin
      chk($sformatf("j%0d a00_row3_addr", id), 64'(wr_q[w0+3].addr), 64'(v.exp_a00_r3));
      chk($sformatf("j%0d b01_row7_addr", id), 64'(wr_q[w0+31].addr), 64'(v.exp_b01_r7));
    end

    repeat (5) @(posedge clk);
    #1;
    chk($sformatf("j%0d busy_after", id), 64'(busy), 64'd0);
    chk($sformatf("j%0d mm_start_cnt", id), 64'(n_start - s0), 64'd1);
    chk($sformatf("j%0d job_done_cnt", id), 64'(n_jdone - j0), 64'd1);
    chk($sformatf("j%0d mm_clear_cnt", id), 64'(n_clear - c0), 64'd1);
    chk($sformatf("j%0d violations", id), 64'(n_viol - v0), 64'd0);
    if (v.exp_busy != 0)
      chk($sformatf("j%0d busy_cycles", id), 64'(n_busy - b0), 64'(v.exp_busy));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " busy"},      64'(busy), 64'd0);
    chk({tag, " in_ready"},  64'(in_ready), 64'd0);
    chk({tag, " out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, " mm_ctl"},    64'({mm_start, mm_clear, job_done}), 64'd0);
    chk({tag, " out_data"},  out_data, 64'd0);
    chk({tag, " ext_addr"},  64'(ext_addr), 64'd0);
    chk({tag, " ext_wdata"}, ext_wdata, 64'd0);
    chk({tag, " we_all"},    64'({we_a00, we_a10, we_b00, we_b01}), 64'd0);
  endtask

  initial begin
    int c0, cyc;
    // ba, bb, bc, st, mode, stall_j, stall_len, dly, extra, ramp, a00r3, b01r7, c_r1, busy
    vecs[0] = '{11'd0,    11'd64,   11'd128,  8'd8,   0, -1, 0,  0, 1'b0, 1'b1, 11'd24,   11'd120,  11'd136, 83};
    vecs[1] = '{11'd256,  11'd512,  11'd768,  8'd8,   1, -1, 0,  5, 1'b0, 1'b0, 11'd280,  11'd568,  11'd776, 0};
    vecs[2] = '{11'd0,    11'd1024, 11'd1536, 8'd16,  0,  5, 10, 3, 1'b0, 1'b0, 11'd48,   11'd1136, 11'd1552, 0};
    vecs[3] = '{11'd2000, 11'd2040, 11'd2040, 8'd8,   2, -1, 0,  0, 1'b0, 1'b0, 11'd2024, 11'd48,   11'd0,   0};
    vecs[4] = '{11'd100,  11'd7,    11'd33,   8'd200, 0,  2, 3,  1, 1'b1, 1'b0, 11'd700,  11'd1407, 11'd233, 0};
    vecs[5] = '{11'd1,    11'd2,    11'd3,    8'd255, 2,  9, 4,  7, 1'b0, 1'b0, 11'd766,  11'd1787, 11'd258, 0};

    resetn = 1'b0; op_start = 1'b0; base_a = '0; base_b = '0; base_c = '0; stride = '0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    resetn = 1'b1;

    for (int t = 0; t < 6; t++) run_job(vecs[t], t);

    // Reset while the matmul is still running.
    c0 = n_clear;
    done_dly = 60;
    @(posedge clk); #1;
    op_start = 1'b1; base_a = 11'd8; base_b = 11'd16; base_c = 11'd24; stride = 8'd8;
    @(posedge clk); #1;
    op_start = 1'b0; in_valid = 1'b1;
    repeat (32) begin
      in_data = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    cyc = 0;
    while (!mm_done && cyc < 200) begin
      if (mm_start) cyc = 1000;
      @(posedge clk); #1;
      cyc++;
    end
    repeat (5) @(posedge clk);
    #1;
    chk("wait busy", 64'(busy), 64'd1);
    chk("wait mm_done_low", 64'(mm_done), 64'd0);
    resetn = 1'b0;
    @(posedge clk); #1;
    chk_reset_outputs("midjob_reset");
    resetn = 1'b1;
    @(negedge clk);
    chk("midjob no_clear", 64'(n_clear - c0), 64'd0);
    run_job(vecs[0], 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
